// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, drain-state encoding and byte-lane merge helper
package mem_pkg;

    localparam int WB_AW     = 27;
    localparam int WB_DW     = 32;
    localparam int WB_MAX_DW = 512;
    localparam int WB_MAX_BW = WB_MAX_DW / 8;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_ISSUE = 1'b1
    } wb_state_t;

    // Callers zero-extend into the widest supported bus and truncate the result.
    function automatic logic [WB_MAX_DW-1:0] merge_lanes(
        input logic [WB_MAX_DW-1:0] old_d,
        input logic [WB_MAX_DW-1:0] new_d,
        input logic [WB_MAX_BW-1:0] be
    );
        logic [WB_MAX_DW-1:0] r;
        r = old_d;
        for (int i = 0; i < WB_MAX_BW; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_d[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/writebuffer_coalesce_if.sv
// rtl/writebuffer_coalesce_if.sv - write, lookup and memory-side signals of the write buffer
interface writebuffer_coalesce_if
    import mem_pkg::*;
#(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
) ();
    localparam int BW = DW / 8;

    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic [BW-1:0] byteen;
    logic          en;
    logic          done;
    logic          flush;
    logic          empty;
    logic          full;

    logic [AW-1:0] lkadr;
    logic          lkhit;
    logic [DW-1:0] lkdata;
    logic [BW-1:0] lkbyteen;

    logic [AW-1:0] memadr;
    logic [DW-1:0] memdata;
    logic [BW-1:0] membyteen;
    logic          memen;
    logic          memdone;

    modport master (
        output adr, data, byteen, en, flush, lkadr, memdone,
        input  done, empty, full, lkhit, lkdata, lkbyteen,
        input  memadr, memdata, membyteen, memen
    );

    modport slave (
        input  adr, data, byteen, en, flush, lkadr, memdone,
        output done, empty, full, lkhit, lkdata, lkbyteen,
        output memadr, memdata, membyteen, memen
    );

endinterface

// File: rtl/wb_entry.sv
// rtl/wb_entry.sv - one write-buffer slot: storage, lane merge and address compare
module wb_entry
    import mem_pkg::*;
#(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              alloc,
    input  logic              merge,
    input  logic              retire,
    input  logic [AW-1:0]     wadr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wbyteen,
    input  logic [AW-1:0]     lkadr,
    output logic              valid,
    output logic [AW-1:0]     adr,
    output logic [DW-1:0]     data,
    output logic [DW/8-1:0]   byteen,
    output logic [DW-1:0]     mdata,
    output logic [DW/8-1:0]   mbyteen,
    output logic              wmatch,
    output logic              lkmatch
);

    // Merged view is exported so the drain path can latch it on the same edge as the merge.
    assign mdata   = DW'(merge_lanes(WB_MAX_DW'(data), WB_MAX_DW'(wdata), WB_MAX_BW'(wbyteen)));
    assign mbyteen = byteen | wbyteen;

    assign wmatch  = valid & (adr == wadr);
    assign lkmatch = valid & (adr == lkadr);

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            valid  <= 1'b0;
            adr    <= '0;
            data   <= '0;
            byteen <= '0;
        end else if (alloc) begin
            valid  <= 1'b1;
            adr    <= wadr;
            data   <= wdata;
            byteen <= wbyteen;
        end else if (merge) begin
            data   <= mdata;
            byteen <= mbyteen;
        end else if (retire) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/writebuffer_coalesce.sv
// rtl/writebuffer_coalesce.sv - coalescing posted-write FIFO between D-cache and memory arbiter
module writebuffer_coalesce
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                  ph1,
    input  logic                  ph2,
    input  logic                  reset,
    writebuffer_coalesce_if.slave bus
);

    localparam int BW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic unused_ph2;
    assign unused_ph2 = ph2;

    logic [PW-1:0] wrptr;
    logic [PW-1:0] rdptr;
    logic [PW-1:0] nxtptr;
    logic [PW-1:0] selptr;
    logic [CW-1:0] count;
    wb_state_t     state;
    logic          issued;

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_wmatch;
    logic [DEPTH-1:0] e_lkmatch;
    logic [DEPTH-1:0] cmatch;
    logic [DEPTH-1:0] alloc;
    logic [DEPTH-1:0] merge;
    logic [DEPTH-1:0] retire;

    logic [AW-1:0] e_adr     [DEPTH];
    logic [DW-1:0] e_data    [DEPTH];
    logic [BW-1:0] e_byteen  [DEPTH];
    logic [DW-1:0] e_mdata   [DEPTH];
    logic [BW-1:0] e_mbyteen [DEPTH];

    logic          any_cmatch;
    logic          accept;
    logic          is_full;
    logic          retiring;
    logic          load_head;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_data;
    logic [BW-1:0] sel_byteen;

    logic          memen_q;
    logic [AW-1:0] memadr_q;
    logic [DW-1:0] memdata_q;
    logic [BW-1:0] membyteen_q;

    logic [DW-1:0] lk_data;
    logic [BW-1:0] lk_byteen;

    assign issued     = (state == WB_ISSUE);
    assign nxtptr     = rdptr + PW'(1);
    assign is_full    = (count == CW'(DEPTH));
    assign any_cmatch = |cmatch;
    assign accept     = bus.en & ~bus.flush & (any_cmatch | ~is_full);
    assign retiring   = issued & bus.memdone;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // The in-flight head is frozen; a same-address write behind it gets its own slot.
            assign cmatch[gi] = e_wmatch[gi] & ~(issued & (rdptr == PW'(gi)));
            assign merge[gi]  = accept & cmatch[gi];
            assign alloc[gi]  = accept & ~any_cmatch & (wrptr == PW'(gi));
            assign retire[gi] = retiring & (rdptr == PW'(gi));

            wb_entry #(
                .AW (AW),
                .DW (DW)
            ) u_entry (
                .ph1     (ph1),
                .reset   (reset),
                .alloc   (alloc[gi]),
                .merge   (merge[gi]),
                .retire  (retire[gi]),
                .wadr    (bus.adr),
                .wdata   (bus.data),
                .wbyteen (bus.byteen),
                .lkadr   (bus.lkadr),
                .valid   (e_valid[gi]),
                .adr     (e_adr[gi]),
                .data    (e_data[gi]),
                .byteen  (e_byteen[gi]),
                .mdata   (e_mdata[gi]),
                .mbyteen (e_mbyteen[gi]),
                .wmatch  (e_wmatch[gi]),
                .lkmatch (e_lkmatch[gi])
            );
        end
    endgenerate

    // Idle loads the head; issue loads its successor once the head completes.
    assign selptr     = issued ? nxtptr : rdptr;
    assign load_head  = issued ? (bus.memdone & e_valid[nxtptr]) : e_valid[rdptr];
    assign sel_adr    = e_adr[selptr];
    assign sel_data   = merge[selptr] ? e_mdata[selptr]   : e_data[selptr];
    assign sel_byteen = merge[selptr] ? e_mbyteen[selptr] : e_byteen[selptr];

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state       <= WB_IDLE;
            wrptr       <= '0;
            rdptr       <= '0;
            count       <= '0;
            memen_q     <= 1'b0;
            memadr_q    <= '0;
            memdata_q   <= '0;
            membyteen_q <= '0;
        end else begin
            if (|alloc) begin
                wrptr <= wrptr + PW'(1);
            end
            count <= count + CW'(|alloc) - CW'(retiring);
            if (retiring) begin
                rdptr <= nxtptr;
            end
            case (state)
                WB_IDLE: begin
                    if (load_head) begin
                        state       <= WB_ISSUE;
                        memen_q     <= 1'b1;
                        memadr_q    <= sel_adr;
                        memdata_q   <= sel_data;
                        membyteen_q <= sel_byteen;
                    end
                end
                WB_ISSUE: begin
                    if (bus.memdone) begin
                        if (load_head) begin
                            memadr_q    <= sel_adr;
                            memdata_q   <= sel_data;
                            membyteen_q <= sel_byteen;
                        end else begin
                            state   <= WB_IDLE;
                            memen_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= WB_IDLE;
                    memen_q <= 1'b0;
                end
            endcase
        end
    end

    // Walk oldest to youngest so younger matches overwrite older lanes.
    always_comb begin
        logic [PW-1:0] idx;
        lk_data   = '0;
        lk_byteen = '0;
        idx       = rdptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rdptr + PW'(k);
            if (e_lkmatch[idx]) begin
                lk_byteen = lk_byteen | e_byteen[idx];
                for (int b = 0; b < BW; b++) begin
                    if (e_byteen[idx][b]) begin
                        lk_data[8*b +: 8] = e_data[idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.done      = accept;
    assign bus.empty     = (count == '0);
    assign bus.full      = is_full;
    assign bus.lkhit     = |e_lkmatch;
    assign bus.lkdata    = lk_data;
    assign bus.lkbyteen  = lk_byteen;
    assign bus.memen     = memen_q;
    assign bus.memadr    = memadr_q;
    assign bus.memdata   = memdata_q;
    assign bus.membyteen = membyteen_q;

endmodule

// File: tb/tb_writebuffer_coalesce.sv
// tb/tb_writebuffer_coalesce.sv - directed and randomized bench for writebuffer_coalesce
module tb_writebuffer_coalesce;

    localparam int DEPTH = 4;
    localparam int AW    = 27;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
        logic [3:0]    be;
    } ent_t;

    logic ph1 = 1'b0;
    logic ph2;
    logic reset;

    int checks = 0;
    int errors = 0;

    ent_t          q[$];
    bit            m_issued;
    logic [AW-1:0] dut_log[$];

    writebuffer_coalesce_if #(.AW(AW), .DW(DW)) bus ();

    writebuffer_coalesce #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ph1 = ~ph1;
    assign ph2 = ~ph1;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lmask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    task automatic drive(input bit e, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        bus.en     = e;
        bus.adr    = a;
        bus.data   = d;
        bus.byteen = b;
    endtask

    // Compare every output against the queue model, then advance one clock.
    task automatic step();
        int          cidx;
        int          oldsz;
        bit          exp_done;
        bit          hit;
        logic [31:0] ld;
        logic [3:0]  lb;
        ent_t        e;
        #1;
        cidx = -1;
        foreach (q[i]) if (q[i].adr == bus.adr && !(i == 0 && m_issued)) cidx = i;
        exp_done = bus.en && !bus.flush && (cidx >= 0 || q.size() < DEPTH);
        chk("done", bus.done, exp_done);
        chk("full", bus.full, q.size() == DEPTH);
        chk("empty", bus.empty, q.size() == 0);
        chk("memen", bus.memen, m_issued);
        if (m_issued) begin
            chk("memadr", bus.memadr, q[0].adr);
            chk("membyteen", bus.membyteen, q[0].be);
            chk("memdata", bus.memdata & lmask(q[0].be), q[0].data & lmask(q[0].be));
        end
        hit = 0; ld = '0; lb = '0;
        foreach (q[i]) begin
            if (q[i].adr == bus.lkadr) begin
                hit = 1;
                lb  = lb | q[i].be;
                for (int b = 0; b < 4; b++) if (q[i].be[b]) ld[8*b +: 8] = q[i].data[8*b +: 8];
            end
        end
        chk("lkhit", bus.lkhit, hit);
        chk("lkbyteen", bus.lkbyteen, lb);
        chk("lkdata", bus.lkdata, ld);
        if (bus.memen && bus.memdone) dut_log.push_back(bus.memadr);
        @(posedge ph1);
        if (exp_done && cidx >= 0) begin
            e = q[cidx];
            for (int b = 0; b < 4; b++) if (bus.byteen[b]) e.data[8*b +: 8] = bus.data[8*b +: 8];
            e.be = e.be | bus.byteen;
            q[cidx] = e;
        end
        oldsz = q.size();
        if (m_issued && bus.memdone) begin
            void'(q.pop_front());
            m_issued = (oldsz > 1);
        end else if (!m_issued && oldsz > 0) begin
            m_issued = 1;
        end
        if (exp_done && cidx < 0) begin
            e.adr = bus.adr; e.data = bus.data; e.be = bus.byteen;
            q.push_back(e);
        end
        @(negedge ph1);
    endtask

    task automatic drain(input string tag);
        bus.en = 0; bus.flush = 0; bus.memdone = 1;
        for (int k = 0; k < 4 * DEPTH && !bus.empty; k++) step();
        bus.memdone = 0;
        step();
        chk(tag, bus.empty, 1);
    endtask

    initial begin
        reset = 0;
        m_issued = 0;
        drive(0, '0, '0, '0);
        bus.flush = 0; bus.memdone = 0; bus.lkadr = '0;
        #2;
        chk("rst_memen", bus.memen, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_lkhit", bus.lkhit, 0);
        chk("rst_lkbyteen", bus.lkbyteen, 0);
        chk("rst_lkdata", bus.lkdata, 0);
        chk("rst_memadr", bus.memadr, 0);
        chk("rst_memdata", bus.memdata, 0);
        @(negedge ph1);
        reset = 1;

        // single write
        drive(1, 27'h0AD, 32'hBEADBEEF, 4'hF);
        bus.lkadr = 27'h0AD;
        #1 chk("t1_done", bus.done, 1);
        step();
        bus.en = 0;
        step();
        #1 chk("t1_memen", bus.memen, 1);
        chk("t1_memadr", bus.memadr, 27'h0AD);
        bus.memdone = 1;
        step();
        bus.memdone = 0;
        #1 chk("t1_empty", bus.empty, 1);
        chk("t1_memen_low", bus.memen, 0);

        // fill to full, blocked fifth write, drain order
        dut_log.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 27'h10 + 27'(i), 32'h1000 + 32'(i), 4'hF);
            step();
        end
        drive(1, 27'h20, 32'h2020, 4'hF);
        #1 chk("t2_full", bus.full, 1);
        chk("t2_blocked", bus.done, 0);
        step();
        bus.memdone = 1;
        #1 chk("t2_blocked_retire", bus.done, 0);
        step();
        bus.memdone = 0;
        #1 chk("t2_accept_later", bus.done, 1);
        step();
        drain("t2_empty");
        chk("t2_drain_n", dut_log.size(), 5);
        if (dut_log.size() == 5) begin
            chk("t2_order0", dut_log[0], 27'h10);
            chk("t2_order1", dut_log[1], 27'h11);
            chk("t2_order2", dut_log[2], 27'h12);
            chk("t2_order3", dut_log[3], 27'h13);
            chk("t2_order4", dut_log[4], 27'h20);
        end

        // coalesce behind an in-flight head
        drive(1, 27'h10, 32'h0, 4'hF);
        step();
        drive(1, 27'h11, 32'h000000AA, 4'h1);
        step();
        drive(1, 27'h11, 32'h0000BB00, 4'h2);
        #1 chk("t3_done", bus.done, 1);
        step();
        bus.en = 0;
        bus.lkadr = 27'h11;
        #1 chk("t3_lkbyteen", bus.lkbyteen, 4'h3);
        chk("t3_lkdata", bus.lkdata, 32'h0000BBAA);
        bus.memdone = 1;
        step();
        bus.memdone = 0;
        #1 chk("t3_memadr", bus.memadr, 27'h11);
        chk("t3_memdata", bus.memdata, 32'h0000BBAA);
        chk("t3_membyteen", bus.membyteen, 4'h3);
        drain("t3_empty");

        // same address as issued head allocates, lookup forwards youngest lanes
        drive(1, 27'h10, 32'h11111111, 4'hF);
        step();
        bus.en = 0;
        step();
        drive(1, 27'h10, 32'h22000000, 4'h8);
        bus.lkadr = 27'h10;
        step();
        bus.en = 0;
        #1 chk("t4_lkhit", bus.lkhit, 1);
        chk("t4_lkdata", bus.lkdata, 32'h22111111);
        chk("t4_lkbyteen", bus.lkbyteen, 4'hF);
        bus.lkadr = 27'h3FF;
        #1 chk("t4_miss_hit", bus.lkhit, 0);
        chk("t4_miss_be", bus.lkbyteen, 0);
        chk("t4_miss_data", bus.lkdata, 0);
        bus.memdone = 1;
        step();
        bus.memdone = 0;
        #1 chk("t4_second_adr", bus.memadr, 27'h10);
        chk("t4_second_be", bus.membyteen, 4'h8);
        drain("t4_empty");

        // asynchronous reset mid-transaction, then flush holds writes off
        for (int i = 0; i < 3; i++) begin
            drive(1, 27'h30 + 27'(i), 32'hC0 + 32'(i), 4'hF);
            step();
        end
        bus.en = 0;
        bus.lkadr = 27'h31;
        step();
        #1 chk("t5_memen_pre", bus.memen, 1);
        reset = 0;
        #1 chk("t5_memen", bus.memen, 0);
        chk("t5_empty", bus.empty, 1);
        chk("t5_lkhit", bus.lkhit, 0);
        q.delete();
        m_issued = 0;
        @(negedge ph1);
        reset = 1;
        bus.flush = 1;
        drive(1, 27'h50, 32'h5050, 4'hF);
        #1 chk("t5_flush_done", bus.done, 0);
        step();
        step();
        bus.flush = 0;
        step();
        bus.en = 0;
        drain("t5_empty_after");

        // randomized traffic over a small address pool
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 7, 27'h40 + 27'($urandom_range(0, 5)), $urandom, 4'($urandom));
            bus.flush   = ($urandom_range(0, 19) == 0);
            bus.memdone = ($urandom_range(0, 9) < 4);
            bus.lkadr   = 27'h40 + 27'($urandom_range(0, 6));
            step();
        end
        drain("final_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writebuffer_coalesce.md
Name: writebuffer_coalesce

Overview:
- Parametrised next-generation write buffer between the data-side cache and the main-memory arbiter.
- Holds up to DEPTH posted writes in a circular FIFO and drains them oldest-first to main memory using the memen/memdone handshake.
- Merges a new write into a pending, not-yet-issued entry with the same word address (byte-lane coalescing).
- Provides a combinational lookup port so the cache can forward buffered data on a read-after-write.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- AW, 27, word-address width.
- DW, 32, data width; multiple of 8.
- BW, DW/8, byte-enable width; derived, not overridden.

Ports:
- ph1  in  1  clock phase 1; all registers update on rising ph1.
- ph2  in  1  clock phase 2; kept for interface uniformity, unused internally.
- reset  in  1  reset, asynchronous, active-low.
- adr  in  AW  write word address.
- data  in  DW  write data.
- byteen  in  BW  write byte lanes.
- en  in  1  write request.
- done  out  1  write accepted this cycle; combinational.
- flush  in  1  stop accepting writes until empty.
- empty  out  1  no valid entries.
- full  out  1  count == DEPTH.
- lkadr  in  AW  lookup address.
- lkhit  out  1  some valid entry matches lkadr.
- lkdata  out  DW  forwarded data.
- lkbyteen  out  BW  lanes covered by matching entries.
- memadr  out  AW  head address to memory.
- memdata  out  DW  head data.
- membyteen  out  BW  head byte lanes.
- memen  out  1  memory write request.
- memdone  in  1  memory completed the current write.

Behaviour:
- Storage: per entry valid, adr, data, byteen. Pointers wrptr and rdptr are log2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH+1) bits.
- Reset (reset low, asynchronous): all valid=0, pointers=0, count=0, issued=0. Outputs: memen=0, empty=1, full=0, lkhit=0, lkbyteen=0. memadr/memdata/membyteen/lkdata=0.
- Coalesce match: a valid entry with adr equal to the input adr that is not the head while issued=1.
- done is high when en & ~flush and either a coalesce match exists or the buffer is not full. done is low whenever en=0.
- Coalescing accept:
  - For each lane set in byteen, the entry's data lane is replaced.
  - The entry's byteen becomes old | new.
  - count and wrptr are unchanged.
  - At most one non-issued entry can ever match an address.
- New-entry accept: written at wrptr; valid=1; wrptr+1; count+1.
- Full: new-entry writes are refused (done=0) even if a retire happens in the same cycle; accepted on a later cycle. Coalescing into a non-head entry is still allowed while full.
- Drain state machine, two states:
  - IDLE (memen=0). If head valid → ISSUE; set issued=1; latch the head into the mem* output registers.
  - ISSUE (memen=1). mem* outputs hold stable. On memdone: clear the head valid, rdptr+1, count-1, issued=0. Then go to ISSUE again if the next entry is valid, otherwise to IDLE.
  - Back-to-back: new mem* values appear the cycle after memdone, with memen staying high.
- Latency: a write into an empty buffer raises memen on the next ph1 edge.
- Simultaneous accept and retire: count changes by +1-1=0. A write to the same address as the head being retired allocates a new entry.
- Lookup (combinational):
  - lkhit = OR of matches over all valid entries.
  - For each lane, lkdata takes the youngest matching entry that has the lane set, where age is its distance from rdptr.
  - lkbyteen = OR of the byteen of all matching entries. Lanes not covered read 0.
- flush: done=0 while flush is high. Draining continues. empty indicates completion.
- memdone while in IDLE is ignored.
- Reset mid-transaction discards all entries and drops memen immediately.

Decomposition:
- Shared package mem_pkg:
  - default widths, WB_AW=27 and WB_DW=32;
  - state encoding WB_IDLE=1'b0 and WB_ISSUE=1'b1;
  - a byte-lane merge function: new lanes overwrite old lanes under the enable mask.
- One sub-module: wb_entry. It holds one entry's registers, applies the coalescing merge, and outputs its address-match flags for the write path and the lookup path.
- The top level instantiates DEPTH wb_entry instances using generate.

Test Plan:
- Single write, adr=0x0AD, data=0xBEADBEEF, byteen=4'hF → done=1. memen rises next cycle with memadr=0x0AD. After memdone: empty=1, memen=0.
- Fill 4 writes, adr 0x10..0x13, with memdone held low → full=1. A 5th write to 0x20 gets done=0. After one memdone it is accepted, and drain order is 0x10,0x11,0x12,0x13,0x20.
- Coalesce, with head 0x10 in flight:
  - Write 0x11 data=0x000000AA byteen=4'h1, then 0x11 data=0x0000BB00 byteen=4'h2 → count stays 2.
  - When 0x11 issues: memdata=0x0000BBAA, membyteen=4'h3.
- In-flight head 0x10 with data=0x11111111, plus a new write 0x10 data=0x22000000 byteen=4'h8 → a second entry is allocated. Lookup of 0x10 gives lkdata=0x22111111, lkbyteen=4'hF, lkhit=1.
- Lookup of an absent address 0x3FF → lkhit=0, lkbyteen=0, lkdata=0.
- Assert reset low while memen=1 with 3 entries buffered → memen, count and lkhit are 0 immediately. After release, flush with a held write keeps done=0.
